// File: rtl/maria_pkg.sv
// Shared types for the Maria bus arbiter: bus ownership states and turnaround counter width.
package maria_pkg;

    typedef enum logic [2:0] {
        BUS_CPU,
        BUS_HALT_PEND,
        BUS_TURN_IN,
        BUS_DMA,
        BUS_TURN_OUT
    } bus_state_t;

    localparam int TURN_W = 2;

endpackage

// File: rtl/maria_bus_arbiter_if.sv
// CPU / DMA / system-bus signal bundle seen by the Maria bus arbiter.
interface maria_bus_arbiter_if;

    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        dma_halt;
    logic        dma_drive;
    logic [15:0] dma_addr;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic        bus_oe;
    logic        cpu_rdy;
    logic        dma_grant;

    modport master (
        input  cpu_addr, cpu_rw, dma_halt, dma_drive, dma_addr,
        output bus_addr, bus_rw, bus_oe, cpu_rdy, dma_grant
    );

    modport slave (
        output cpu_addr, cpu_rw, dma_halt, dma_drive, dma_addr,
        input  bus_addr, bus_rw, bus_oe, cpu_rdy, dma_grant
    );

endinterface

// File: rtl/maria_sat_counter.sv
// Saturating up-counter with a clear that wins over increment, except that clear+inc loads 1.
module maria_sat_counter #(
    parameter int W = 9
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/maria_bus_arbiter.sv
// Shares the system address bus between the 6502 and the Maria DMA engine: HALT becomes a
// CPU stall, owner changes get an undriven turnaround gap, and stolen cycles are counted per line.
module maria_bus_arbiter #(
    parameter int TURN_CYCLES = 1,
    parameter int WDOG_CYCLES = 511,
    parameter int CNT_W       = 9
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                mclk0,
    input  logic                pclk1,
    input  logic                line_start,
    maria_bus_arbiter_if.master bus,
    output logic [CNT_W-1:0]    stolen_cnt,
    output logic                dma_timeout
);
    import maria_pkg::*;

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    bus_state_t        state_q, state_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [15:0]       addr_q, addr_d;
    logic              timeout_q, timeout_d;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              in_dma;
    logic              in_turn;
    logic              turn_done;
    logic              wdog_expired;
    logic              wdog_clr;
    logic              rw_c;
    logic              oe_c;

    assign in_dma       = (state_q == BUS_DMA);
    assign in_turn      = (state_q == BUS_TURN_IN) || (state_q == BUS_TURN_OUT);
    assign turn_done    = (turn_q == TURN_W'(TURN_CYCLES - 1));
    assign wdog_expired = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    // The grant waits for a read cycle boundary because the 6502 only honours RDY on reads.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        case (state_q)
            BUS_CPU: begin
                if (bus.dma_halt) state_d = BUS_HALT_PEND;
            end
            BUS_HALT_PEND: begin
                if (!bus.dma_halt)                state_d = BUS_CPU;
                else if (pclk1 && bus.cpu_rw)     state_d = BUS_TURN_IN;
            end
            BUS_TURN_IN: begin
                if (turn_done) state_d = BUS_DMA;
            end
            BUS_DMA: begin
                if (wdog_expired) begin
                    timeout_d = 1'b1;
                    state_d   = BUS_TURN_OUT;
                end else if (!bus.dma_halt) begin
                    state_d = BUS_TURN_OUT;
                end
            end
            BUS_TURN_OUT: begin
                if (turn_done) state_d = BUS_CPU;
            end
            default: state_d = BUS_CPU;
        endcase
    end

    assign turn_d   = ((state_d != state_q) || !in_turn) ? '0 : turn_q + TURN_W'(1);
    assign wdog_clr = (state_d == BUS_TURN_IN) && (state_q != BUS_TURN_IN);

    // Undriven or idle-DMA ticks reuse addr_q so the bus keeps showing the last driven address.
    always_comb begin
        addr_d = addr_q;
        rw_c   = 1'b1;
        oe_c   = 1'b0;
        case (state_q)
            BUS_CPU, BUS_HALT_PEND: begin
                addr_d = bus.cpu_addr;
                rw_c   = bus.cpu_rw;
                oe_c   = 1'b1;
            end
            BUS_DMA: begin
                oe_c = bus.dma_drive;
                if (bus.dma_drive) addr_d = bus.dma_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BUS_CPU;
            turn_q    <= '0;
            addr_q    <= '0;
            timeout_q <= 1'b0;
        end else if (mclk0) begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            addr_q    <= addr_d;
            timeout_q <= timeout_d;
        end
    end

    maria_sat_counter #(.W(CNT_W)) u_stolen (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (mclk0),
        .clr     (line_start),
        .inc     (in_dma),
        .q       (stolen_cnt)
    );

    maria_sat_counter #(.W(WDOG_W)) u_wdog (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (mclk0),
        .clr     (wdog_clr),
        .inc     (in_dma),
        .q       (wdog_cnt)
    );

    assign bus.bus_addr  = reset_n ? addr_d : 16'h0000;
    assign bus.bus_rw    = reset_n ? rw_c : 1'b1;
    assign bus.bus_oe    = oe_c;
    assign bus.cpu_rdy   = (state_q == BUS_CPU);
    assign bus.dma_grant = in_dma;
    assign dma_timeout   = timeout_q;

endmodule
